// File: rtl/tree_ensemble_vote_sched.sv
// Time-shares one external tree bank across an ensemble vote; latency 1+N_TREES*(1+EVAL_WAIT) from accept to out_valid.
// Backpressure: the result is held in DONE until out_ready; in_ready stays low from accept until the cycle after release.
module tree_ensemble_vote_sched #(
  parameter int N_FEAT    = 51,
  parameter int N_TREES   = 8,
  parameter int EVAL_WAIT = 0,
  parameter bit TIE_CLASS = 1'b0,
  localparam int SEL_W    = (N_TREES > 1) ? $clog2(N_TREES) : 1,
  localparam int VOTE_W   = $clog2(N_TREES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_FEAT-1:0] in_feat,
  output logic [N_FEAT-1:0] feat_o,
  output logic [SEL_W-1:0]  tree_sel,
  input  logic              tree_vote_i,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_class,
  output logic [VOTE_W-1:0] out_votes
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  localparam logic [3:0]        WAIT_LAST = 4'(EVAL_WAIT);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(N_TREES - 1);
  localparam logic [VOTE_W:0]   N_CMP     = (VOTE_W + 1)'(N_TREES);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic [VOTE_W-1:0] vote_cnt;
  logic [VOTE_W-1:0] final_votes;
  logic [VOTE_W:0]   votes_x2;
  logic              maj_class;

  // One extra bit on the doubled count keeps the majority compare overflow-free.
  always_comb begin
    final_votes = vote_cnt + VOTE_W'(tree_vote_i);
    votes_x2    = {final_votes, 1'b0};
    if (votes_x2 > N_CMP)
      maj_class = 1'b1;
    else if (votes_x2 == N_CMP)
      maj_class = TIE_CLASS;
    else
      maj_class = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_class <= 1'b0;
      out_votes <= '0;
      feat_o    <= '0;
      tree_sel  <= '0;
      wait_cnt  <= '0;
      vote_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            feat_o   <= in_feat;
            tree_sel <= '0;
            wait_cnt <= '0;
            vote_cnt <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= EVAL;
          end
        end
        EVAL: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            vote_cnt <= final_votes;
            if (tree_sel == SEL_LAST) begin
              out_votes <= final_votes;
              out_class <= maj_class;
              out_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end else begin
              tree_sel <= tree_sel + SEL_W'(1);
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tree_ensemble_vote_sched.md
Name: tree_ensemble_vote_sched

Overview:
- Sequencer that time-shares one bank of combinational decision-tree classifiers across an ensemble vote.
- Accepts one feature vector per valid/ready handshake and holds it on a shared feature bus.
- Steps a tree-select index through every tree, accumulates the 1-bit class votes and returns a majority class with the vote count.
- Sits between the sample source and the per-tree classifier bank, which is wrapped by an external N_TREES:1 mux on tree_sel.

Parameters:
- N_FEAT, 51: feature vector width; matches the classifier input width.
- N_TREES, 8: number of trees in the ensemble; legal range 1 to 255.
- EVAL_WAIT, 0: extra settle cycles per tree before its vote is sampled; legal range 0 to 15.
- TIE_CLASS, 0: class emitted when votes*2 equals N_TREES.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  feature vector on in_feat is valid.
- in_ready  out  1  block can accept a sample.
- in_feat  in  N_FEAT  feature vector.
- feat_o  out  N_FEAT  registered feature bus driving all trees.
- tree_sel  out  clog2(N_TREES), min 1  index of the tree whose output is on tree_vote_i.
- tree_vote_i  in  1  class output of the selected tree; combinational from feat_o and tree_sel.
- busy  out  1  high while in EVAL.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_class  out  1  majority class.
- out_votes  out  clog2(N_TREES+1)  number of trees that voted class 1.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values:
  - state = IDLE, in_ready = 1, busy = 0, out_valid = 0.
  - out_class = 0, out_votes = 0, feat_o = 0, tree_sel = 0.
  - Internal vote counter and wait counter = 0.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: feat_o <= in_feat, tree_sel <= 0, wait counter <= 0, vote counter <= 0, then go to EVAL.
- EVAL:
  - in_ready = 0, busy = 1.
  - Each tree occupies a slot of 1+EVAL_WAIT cycles. The wait counter counts 0..EVAL_WAIT.
  - In the last cycle of a slot (wait counter == EVAL_WAIT), tree_vote_i is sampled into the vote counter and tree_sel advances.
  - On the last slot (tree_sel == N_TREES-1), there is no increment of tree_sel past N_TREES-1. Instead:
    - final_votes = accumulated votes plus this cycle's vote.
    - out_votes <= final_votes.
    - out_class <= rule below.
    - out_valid <= 1, then go to DONE.
- Majority rule:
  - final_votes*2 > N_TREES gives 1.
  - final_votes*2 == N_TREES gives TIE_CLASS.
  - Otherwise 0.
  - Compare at width clog2(N_TREES+1)+1 so the result never overflows.
- DONE:
  - out_valid = 1.
  - out_class, out_votes and feat_o are held stable until out_ready.
  - in_ready = 0. in_valid is ignored; the source must hold its sample.
  - On out_ready: out_valid <= 0, then go to IDLE. in_ready rises the next cycle, so there is no back-to-back overlap.
- Latency: accept at cycle t gives out_valid at cycle t + 1 + N_TREES*(1+EVAL_WAIT). Defaults: t+9.
- Throughput: one sample per N_TREES*(1+EVAL_WAIT) + 2 cycles when out_ready is held high.
- feat_o changes only on an accepted input. tree_sel holds its last value in DONE and returns to 0 on the next accept.
- Reset mid-operation: rst in EVAL or DONE discards the sample and partial votes. All outputs return to reset values on the next edge; no out_valid is produced.
- in_valid is ignored while rst is asserted.
- N_TREES=1: single slot; out_class = vote, because votes*2 > 1 iff the vote is 1.

Test Plan:
- Reset: assert rst for 2 cycles -> in_ready=1, out_valid=0, out_votes=0, tree_sel=0, feat_o=0.
- Defaults, bank model where trees 0,2,4,5,7 vote 1 -> out_valid exactly 9 cycles after accept, out_votes=5, out_class=1, tree_sel sequence 0..7 one step per cycle.
- Tie: N_TREES=8, trees 0-3 vote 1 -> out_votes=4; out_class=0 with TIE_CLASS=0, and out_class=1 with TIE_CLASS=1.
- EVAL_WAIT=2, N_TREES=4, all trees vote 1:
  - Each tree_sel value is held 3 cycles.
  - out_valid at accept+13, out_votes=4, out_class=1.
  - A vote change on non-final slot cycles does not affect the count.
- Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 with a new vector:
  - out_valid, out_class, out_votes and feat_o are stable; in_ready=0.
  - On out_ready=1, IDLE follows, then the new sample is accepted.
- Mid-EVAL reset: rst pulsed at the 4th EVAL cycle -> no out_valid; the next sample, with all trees voting 0, gives out_votes=0, out_class=0 with no carry-over of stale votes.
